// File: rtl/csi_tx_packetizer.sv
`default_nettype none
// ============================================================================
// csi_tx_packetizer : byte-serial CSI-2 packet builder (header, payload, CRC).
// Define CSI_TX_CRC_EN to compute the footer CRC; otherwise footer is 00,00.
// Revision: 1.0
// ============================================================================
module csi_tx_packetizer #(
  parameter logic [1:0] VC_ID       = 2'd0,
  parameter logic [5:0] LONG_DT_MIN = 6'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_start,
  input  logic [5:0]  pkt_dt,
  input  logic [15:0] pkt_wc,
  output logic        pkt_ready,
  input  logic [7:0]  pay_data,
  input  logic        pay_valid,
  output logic        pay_ready,
  output logic [7:0]  mipi_data,
  output logic        tx_valid,
  output logic        start_of_packet,
  output logic        end_of_packet,
  output logic        underrun
);

  // S_LAST covers the cycle the final byte is on the wire, forcing one idle gap.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
    S_CRC  = 3'd3,
    S_LAST = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [15:0] r_rem, w_rem_nxt;
  logic [7:0]  r_di;
  logic [15:0] r_wc;
  logic        r_long;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_sop, w_sop_nxt;
  logic        r_eop, w_eop_nxt;
  logic        r_underrun;
  logic        w_accept, w_hs, w_underrun_set;
  logic [5:0]  w_ecc;
  logic [15:0] w_crc;

  function automatic logic [5:0] calc_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  assign pkt_ready       = (r_state == S_IDLE);
  assign pay_ready       = (r_state == S_PAY) && (r_rem != 16'd0);
  assign w_accept        = pkt_start && pkt_ready;
  assign w_hs            = pay_valid && pay_ready;
  assign w_underrun_set  = pay_ready && !pay_valid;
  assign w_ecc           = calc_ecc({r_wc, r_di});
  assign mipi_data       = r_data;
  assign tx_valid        = r_valid;
  assign start_of_packet = r_sop;
  assign end_of_packet   = r_eop;
  assign underrun        = r_underrun;

`ifdef CSI_TX_CRC_EN
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] v;
    v = c;
    for (int i = 0; i < 8; i++) begin
      v = (v[0] ^ d[i]) ? ((v >> 1) ^ 16'h8408) : (v >> 1);
    end
    return v;
  endfunction

  logic [15:0] r_crc;

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_crc <= 16'hFFFF;
    end else if (w_hs) begin
      r_crc <= crc_byte(r_crc, pay_data);
    end
  end

  assign w_crc = r_crc;
`else
  assign w_crc = 16'h0000;
`endif

  // Each state computes the byte that appears on mipi_data in the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rem_nxt   = r_rem;
    w_data_nxt  = 8'h00;
    w_valid_nxt = 1'b0;
    w_sop_nxt   = 1'b0;
    w_eop_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_data_nxt  = {VC_ID, pkt_dt};
          w_valid_nxt = 1'b1;
          w_sop_nxt   = 1'b1;
          w_idx_nxt   = 2'd1;
          w_rem_nxt   = pkt_wc;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        w_valid_nxt = 1'b1;
        w_idx_nxt   = r_idx + 2'd1;
        case (r_idx)
          2'd1:    w_data_nxt = r_wc[7:0];
          2'd2:    w_data_nxt = r_wc[15:8];
          default: begin
            w_data_nxt = {2'b00, w_ecc};
            w_idx_nxt  = 2'd0;
            if (!r_long) begin
              w_eop_nxt   = 1'b1;
              w_state_nxt = S_LAST;
            end else if (r_wc == 16'd0) begin
              w_state_nxt = S_CRC;
            end else begin
              w_state_nxt = S_PAY;
            end
          end
        endcase
      end
      S_PAY: begin
        if (w_hs) begin
          w_data_nxt  = pay_data;
          w_valid_nxt = 1'b1;
          w_rem_nxt   = r_rem - 16'd1;
          if (r_rem == 16'd1) begin
            w_state_nxt = S_CRC;
          end
        end
      end
      S_CRC: begin
        w_valid_nxt = 1'b1;
        if (r_idx == 2'd0) begin
          w_data_nxt = w_crc[7:0];
          w_idx_nxt  = 2'd1;
        end else begin
          w_data_nxt  = w_crc[15:8];
          w_eop_nxt   = 1'b1;
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_LAST;
        end
      end
      S_LAST:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_rem      <= 16'd0;
      r_di       <= 8'h00;
      r_wc       <= 16'h0000;
      r_long     <= 1'b0;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rem   <= w_rem_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_sop   <= w_sop_nxt;
      r_eop   <= w_eop_nxt;
      if (w_accept) begin
        r_di   <= {VC_ID, pkt_dt};
        r_wc   <= pkt_wc;
        r_long <= (pkt_dt >= LONG_DT_MIN);
      end
      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csi_tx_packetizer.sv
`default_nettype none
// ============================================================================
// tb_csi_tx_packetizer : directed bench for csi_tx_packetizer.
// Revision: 1.0
// ============================================================================
module tb_csi_tx_packetizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pkt_start, pay_valid;
  logic [5:0]  pkt_dt;
  logic [15:0] pkt_wc;
  logic [7:0]  pay_data;
  logic        pkt_ready, pay_ready, tx_valid, sop, eop, underrun;
  logic [7:0]  mipi_data;

  logic        h_pkt_start, h_pay_valid;
  logic [5:0]  h_pkt_dt;
  logic [15:0] h_pkt_wc;
  logic [7:0]  h_pay_data;
  logic        h_pkt_ready, h_pay_ready, h_tx_valid, h_sop, h_eop, h_underrun;
  logic [7:0]  h_mipi_data;

  csi_tx_packetizer u_dut (
    .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_dt(pkt_dt), .pkt_wc(pkt_wc),
    .pkt_ready(pkt_ready), .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
    .mipi_data(mipi_data), .tx_valid(tx_valid), .start_of_packet(sop),
    .end_of_packet(eop), .underrun(underrun)
  );

  csi_tx_packetizer #(.VC_ID(2'd0), .LONG_DT_MIN(6'h38)) u_dut_hi (
    .clk(clk), .rst(rst), .pkt_start(h_pkt_start), .pkt_dt(h_pkt_dt), .pkt_wc(h_pkt_wc),
    .pkt_ready(h_pkt_ready), .pay_data(h_pay_data), .pay_valid(h_pay_valid),
    .pay_ready(h_pay_ready), .mipi_data(h_mipi_data), .tx_valid(h_tx_valid),
    .start_of_packet(h_sop), .end_of_packet(h_eop), .underrun(h_underrun)
  );

`ifdef CSI_TX_CRC_EN
  localparam logic [15:0] c_FOOT_24 = 16'h00F0;
  localparam logic [15:0] c_FOOT_0  = 16'hFFFF;
`else
  localparam logic [15:0] c_FOOT_24 = 16'h0000;
  localparam logic [15:0] c_FOOT_0  = 16'h0000;
`endif

  typedef struct {
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [7:0]  h0, h1, h2, h3;
    int          n;
    bit          lng;
    logic [15:0] foot;
  } vec_t;

  vec_t vt[4];

  logic [7:0] pl [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                          8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                          8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

  int checks = 0;
  int failures = 0;

  logic [7:0] cap_d[$];
  bit         cap_s[$], cap_e[$], cap_r[$];
  int         cap_t[$];
  logic [7:0] exp_q[$];
  int         eop_cnt = 0;
  int         cyc = 0;
  bit         rdy_seen = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst && tx_valid) begin
      cap_d.push_back(mipi_data);
      cap_s.push_back(sop);
      cap_e.push_back(eop);
      cap_r.push_back(pkt_ready);
      cap_t.push_back(cyc);
      if (eop) eop_cnt = eop_cnt + 1;
    end
    if (pay_ready) rdy_seen = 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic clr();
    cap_d.delete(); cap_s.delete(); cap_e.delete(); cap_r.delete(); cap_t.delete();
    exp_q.delete();
    eop_cnt  = 0;
    rdy_seen = 0;
  endtask

  task automatic build_exp(input vec_t v);
    exp_q.push_back(v.h0); exp_q.push_back(v.h1);
    exp_q.push_back(v.h2); exp_q.push_back(v.h3);
    if (v.lng) begin
      for (int i = 0; i < v.n; i++) exp_q.push_back(pl[i]);
      exp_q.push_back(v.foot[7:0]);
      exp_q.push_back(v.foot[15:8]);
    end
  endtask

  task automatic cmp_cap(input string nm);
    int m;
    chk({nm, "_len"}, cap_d.size(), exp_q.size());
    m = (cap_d.size() < exp_q.size()) ? cap_d.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s_b%0d", nm, i), cap_d[i], exp_q[i]);
    chk({nm, "_sop"}, cap_s[0], 1);
    chk({nm, "_eop"}, cap_e[cap_e.size() - 1], 1);
  endtask

  task automatic wait_eop(input int target, input string nm);
    int t = 0;
    while (eop_cnt < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (eop_cnt < target) fail_now({nm, "_eop_wait"});
    @(negedge clk);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_data"}, mipi_data, 8'h00);
    chk({nm, "_txv"}, tx_valid, 1'b0);
    chk({nm, "_sop"}, sop, 1'b0);
    chk({nm, "_eop"}, eop, 1'b0);
    chk({nm, "_unr"}, underrun, 1'b0);
    chk({nm, "_payrdy"}, pay_ready, 1'b0);
    chk({nm, "_pktrdy"}, pkt_ready, 1'b1);
  endtask

  // gap_at/gap_len insert a pay_valid hole; abort_at asserts rst after that many bytes.
  task automatic send_pkt(input logic [5:0] dt, input logic [15:0] wc, input int n,
                          input int gap_at, input int gap_len, input int abort_at,
                          input bit poke);
    int t = 0;
    int k = 0;
    int gl = gap_len;
    @(negedge clk);
    while (!pkt_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!pkt_ready) fail_now("pkt_ready_wait");
    pkt_start = 1'b1;
    pkt_dt    = dt;
    pkt_wc    = wc;
    t = 0;
    while (k < n && k != abort_at && t < 400) begin
      @(negedge clk);
      t++;
      pkt_start = poke && (k == 3);
      if (pay_ready) begin
        if (k == gap_at && gl > 0) begin
          pay_valid = 1'b0;
          gl--;
        end else begin
          pay_valid = 1'b1;
          pay_data  = pl[k];
          k++;
        end
      end else begin
        pay_valid = 1'b0;
      end
    end
    if (t >= 400) fail_now("payload_feed");
    @(negedge clk);
    pkt_start = 1'b0;
    pay_valid = 1'b0;
    if (abort_at >= 0 && k == abort_at) rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pkt_start = 1'b0; pkt_dt = '0; pkt_wc = '0; pay_data = '0; pay_valid = 1'b0;
    h_pkt_start = 1'b0; h_pkt_dt = '0; h_pkt_wc = '0; h_pay_data = '0; h_pay_valid = 1'b0;

    vt[0] = '{dt: 6'h00, wc: 16'h0000, h0: 8'h00, h1: 8'h00, h2: 8'h00, h3: 8'h00,
              n: 0, lng: 1'b0, foot: 16'h0000};
    vt[1] = '{dt: 6'h01, wc: 16'h1234, h0: 8'h01, h1: 8'h34, h2: 8'h12, h3: 8'h06,
              n: 0, lng: 1'b0, foot: 16'h0000};
    vt[2] = '{dt: 6'h2B, wc: 16'h0018, h0: 8'h2B, h1: 8'h18, h2: 8'h00, h3: 8'h14,
              n: 24, lng: 1'b1, foot: c_FOOT_24};
    vt[3] = '{dt: 6'h12, wc: 16'h0000, h0: 8'h12, h1: 8'h00, h2: 8'h00, h3: 8'h18,
              n: 0, lng: 1'b1, foot: c_FOOT_0};

    repeat (3) @(negedge clk);
    check_reset("rst_init");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      clr();
      build_exp(vt[i]);
      send_pkt(vt[i].dt, vt[i].wc, vt[i].n, -1, 0, -1, 1'b0);
      wait_eop(1, $sformatf("vec%0d", i));
      cmp_cap($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_payrdy_seen", i), rdy_seen, (vt[i].n != 0));
    end

    // ECC on a short packet whose data type would be long in the default build
    @(negedge clk);
    h_pkt_start = 1'b1; h_pkt_dt = 6'h37; h_pkt_wc = 16'h01F0;
    @(negedge clk);
    h_pkt_start = 1'b0;
    chk("ecc_b0", {h_tx_valid, h_sop, h_mipi_data}, {1'b1, 1'b1, 8'h37});
    @(negedge clk);
    chk("ecc_b1", {h_tx_valid, h_mipi_data}, {1'b1, 8'hF0});
    @(negedge clk);
    chk("ecc_b2", {h_tx_valid, h_mipi_data}, {1'b1, 8'h01});
    @(negedge clk);
    chk("ecc_b3", {h_tx_valid, h_eop, h_pkt_ready, h_mipi_data}, {1'b1, 1'b1, 1'b0, 8'h3F});
    @(negedge clk);
    chk("ecc_after", {h_tx_valid, h_pkt_ready, h_pay_ready, h_underrun}, 4'b0100);

    // Underrun: 3-cycle hole mid-payload plus an ignored pkt_start while busy
    chk("unr_pre", underrun, 1'b0);
    clr();
    build_exp(vt[2]);
    send_pkt(vt[2].dt, vt[2].wc, 24, 10, 3, -1, 1'b1);
    wait_eop(1, "unr");
    cmp_cap("unr");
    chk("unr_flag", underrun, 1'b1);
    chk("unr_gap", (cap_t[cap_t.size() - 1] - cap_t[0] + 1) - cap_t.size(), 3);

    clr();
    build_exp(vt[0]);
    send_pkt(vt[0].dt, vt[0].wc, 0, -1, 0, -1, 1'b0);
    wait_eop(1, "sticky");
    cmp_cap("sticky");
    chk("unr_sticky", underrun, 1'b1);

    // Back-to-back short packets: exactly one idle cycle between them
    clr();
    build_exp(vt[0]);
    build_exp(vt[1]);
    send_pkt(vt[0].dt, vt[0].wc, 0, -1, 0, -1, 1'b0);
    send_pkt(vt[1].dt, vt[1].wc, 0, -1, 0, -1, 1'b0);
    wait_eop(2, "b2b");
    cmp_cap("b2b");
    chk("b2b_gap", cap_t[4] - cap_t[3], 2);
    chk("b2b_rdy_at_eop", cap_r[3], 1'b0);

    // Reset while the fifth payload byte is on the wire
    clr();
    send_pkt(vt[2].dt, vt[2].wc, 24, -1, 0, 5, 1'b0);
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;
    clr();
    build_exp(vt[1]);
    send_pkt(vt[1].dt, vt[1].wc, 0, -1, 0, -1, 1'b0);
    wait_eop(1, "post_rst");
    cmp_cap("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
